ws281x_stream_driver: RTL
=========================

// Module: ws281x_stream_driver
// PURPOSE
//  Parametrised WS281x-family serial LED driver: accepts pixels on a valid/ready stream, applies
//  global brightness and channel ordering, and emits the one-wire NRZ waveform on dout.
//  Generalises the single-strip blink driver to any frame length, clock rate, RGB/RGBW and colour
//  order, and adds underrun detection. Sits between the pattern/decode logic and the strip pin.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency
//  BIT_HZ      800_000     serial bit rate; CYC = CLK_HZ/BIT_HZ (62 at default)
//  T0H_PCT     32          high time of a '0' bit, % of CYC; T0H = CYC*T0H_PCT/100 (19)
//  T1H_PCT     64          high time of a '1' bit, % of CYC; T1H = CYC*T1H_PCT/100 (39)
//  RESET_US    80          latch low time; RST_CYC = RESET_US*(CLK_HZ/1_000_000) (4000)
//  MAX_LEDS    256         largest frame; IDX_W = clog2(MAX_LEDS+1)
//  RGBW        0           0: 24 bits/LED; 1: 32 bits/LED (W sent last)
//  ORDER       ORDER_GRB   channel order from ws281x_pkg (GRB, RGB, BRG)
//  UNDER_CYC   RST_CYC/2   max low gap between pixels before underrun is declared
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      synchronous reset, active low
//  frame_start  in   1      1-cycle request to start a frame (sampled only in IDLE)
//  frame_len    in   IDX_W  LEDs in frame, latched with frame_start; 0 => request ignored
//  brightness   in   8      global scale, latched with frame_start; 255 = unity
//  pix_valid    in   1      pixel available
//  pix_ready    out  1      driver accepts pixel this cycle
//  pix_r/g/b/w  in   8 each pixel channels; pix_w ignored when RGBW=0
//  dout         out  1      strip data line
//  busy         out  1      high in every state except IDLE
//  pix_done     out  1      1-cycle pulse after the last bit of each LED
//  frame_done   out  1      1-cycle pulse when latch time completes
//  underrun     out  1      1-cycle pulse when pixel gap exceeds UNDER_CYC
// BEHAVIOUR
//  Reset (reset_n=0 at edge): dout=0, pix_ready=0, pix_done=frame_done=underrun=0, busy=1, state
//   LATCH, counters 0. After release, LATCH runs full RST_CYC, then frame_done pulses, enters IDLE.
//  Reset mid-frame: same as above; the partial frame is dropped and dout goes low on that edge.
//  IDLE: dout=0. frame_start && frame_len!=0 -> latch len/brightness, led_cnt=0, -> WAIT.
//   frame_start while busy is ignored (no queueing).
//  WAIT: pix_ready=1 (combinational from state), dout=0, gap counter increments.
//   pix_valid&&pix_ready -> scale each channel: c' = (c*(brightness+1))>>8 (16-bit product),
//   pack in ORDER (W last if RGBW) into shift reg, bit_cnt=BPL-1, -> SEND.
//   gap counter reaches UNDER_CYC-1 with no pixel -> underrun pulse, -> LATCH (frame aborted).
//   Gap counter clears on entry to WAIT; first pixel of frame is also subject to the timeout.
//  SEND: per bit, phase counter 0..CYC-1; dout=1 for phase < T0H (MSB=0) or < T1H (MSB=1), else 0.
//   At phase CYC-1: shift left; if bit_cnt==0 -> pix_done pulse, led_cnt++; if led_cnt==len-1
//   -> LATCH else -> WAIT; otherwise bit_cnt--, next bit starts on the following cycle (no gap).
//   MSB of first channel is sent first; each bit period is exactly CYC cycles.
//  LATCH: dout=0 for RST_CYC cycles; last cycle -> frame_done pulse (also after underrun), -> IDLE.
//  Frame latency: frame_start to first dout rise >= 2 cycles (IDLE->WAIT, accept, SEND).
//  Frame length 1 and MAX_LEDS both legal; led_cnt never wraps.
//  Elaboration check: T0H < T1H < CYC, else $error.
// STRUCTURE
//  ws281x_pkg: ORDER_* constants, state enum (IDLE, WAIT, SEND, LATCH), clog2 function.
//  Sub-module ws281x_bit_timer: phase counter + dout compare for one bit (in: start, bit;
//   out: dout, bit_end). Top holds FSM, shift register, scaler, led/gap/latch counters.
// TESTING
//  1 Default params, release reset -> dout low, busy=1 for 4000 cycles, frame_done, busy=0.
//  2 len=1, brightness=255, GRB, pixel R=0xFF G=0x00 B=0x0F -> 24 bits: 8x(19 high),
//    8x(39 high), 4x19+4x39; each bit 62 cycles; pix_done, 4000-cycle low, frame_done.
//  3 brightness=127, R=0xFF -> transmitted R byte 0x7F; brightness=0 -> all channels 0x00.
//  4 len=3, pix_valid held low 2000 cycles after pixel 1 -> underrun pulse, LATCH, frame_done,
//    only 24 bits on dout; frame_start during busy ignored.
//  5 RGBW=1, ORDER_RGB, W=0x80 -> 32 bits, W byte last (1 then seven 0).
//  6 reset_n low mid-bit of pixel 2 -> dout=0 next edge, 4000-cycle latch, then IDLE.

Source files
------------

// File: rtl/ws281x_pkg.sv
// Shared types and helpers for the WS281x stream driver.
package ws281x_pkg;

    localparam int ORDER_GRB = 0;
    localparam int ORDER_RGB = 1;
    localparam int ORDER_BRG = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND,
        S_LATCH
    } state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Brightness 255 maps to unity because the scale factor is brightness+1.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] bri);
        logic [15:0] prod;
        prod = {8'h00, c} * ({8'h00, bri} + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws281x_bit_timer.sv
// One NRZ bit period: phase counter and high-time compare. Held in start for the whole
// SEND state; the phase wraps at bit_end so consecutive bits abut with no gap.
module ws281x_bit_timer
    import ws281x_pkg::*;
#(
    parameter int CYC = 62,
    parameter int T0H = 19,
    parameter int T1H = 39
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic bit_end
);

    localparam int PH_W = clog2(CYC + 1);

    logic [PH_W-1:0] phase;

    assign bit_end = start && (phase == PH_W'(CYC - 1));
    assign dout    = start && (phase < (bit_val ? PH_W'(T1H) : PH_W'(T0H)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase <= '0;
        end else if (!start || bit_end) begin
            phase <= '0;
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

endmodule

// File: rtl/ws281x_stream_driver.sv
// WS281x serial LED driver: pixel stream in, brightness scale and channel reorder,
// NRZ waveform out with latch timing and underrun detection.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_IDLE  | line low, waiting for frame_start with non-zero length
//  S_WAIT  | pix_ready high, waiting for next pixel; gap timer running
//  S_SEND  | shifting one LED's bits out, MSB first
//  S_LATCH | line held low RST_CYC cycles; also the reset/abort state
module ws281x_stream_driver
    import ws281x_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BIT_HZ    = 800_000,
    parameter int T0H_PCT   = 32,
    parameter int T1H_PCT   = 64,
    parameter int RESET_US  = 80,
    parameter int MAX_LEDS  = 256,
    parameter int RGBW      = 0,
    parameter int ORDER     = ORDER_GRB,
    parameter int UNDER_CYC = (RESET_US * (CLK_HZ / 1_000_000)) / 2,
    localparam int IDX_W    = clog2(MAX_LEDS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic [IDX_W-1:0] frame_len,
    input  logic [7:0]       brightness,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [7:0]       pix_r,
    input  logic [7:0]       pix_g,
    input  logic [7:0]       pix_b,
    input  logic [7:0]       pix_w,
    output logic             dout,
    output logic             busy,
    output logic             pix_done,
    output logic             frame_done,
    output logic             underrun
);

    localparam int CYC     = CLK_HZ / BIT_HZ;
    localparam int T0H     = CYC * T0H_PCT / 100;
    localparam int T1H     = CYC * T1H_PCT / 100;
    localparam int RST_CYC = RESET_US * (CLK_HZ / 1_000_000);
    localparam int BPL     = (RGBW != 0) ? 32 : 24;
    localparam int GAP_W   = clog2(UNDER_CYC + 1);
    localparam int LAT_W   = clog2(RST_CYC + 1);

    generate
        if (!(T0H < T1H && T1H < CYC)) begin : g_bad_timing
            $error("ws281x_stream_driver: need T0H < T1H < CYC");
        end
    endgenerate

    state_t           state, state_next;
    logic [IDX_W-1:0] len_q, led_cnt;
    logic [7:0]       bri_q;
    logic [31:0]      shreg, packed_pix;
    logic [4:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             dout_q, timer_dout, bit_end;
    logic [7:0]       r_s, g_s, b_s, w_s;

    ws281x_bit_timer #(
        .CYC (CYC),
        .T0H (T0H),
        .T1H (T1H)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (state == S_SEND),
        .bit_val (shreg[31]),
        .dout    (timer_dout),
        .bit_end (bit_end)
    );

    // Pixels are left-aligned in the 32-bit shift register; RGB mode never shifts the low byte out.
    always_comb begin
        r_s = scale8(pix_r, bri_q);
        g_s = scale8(pix_g, bri_q);
        b_s = scale8(pix_b, bri_q);
        w_s = (RGBW != 0) ? scale8(pix_w, bri_q) : 8'h00;
        case (ORDER)
            ORDER_RGB: packed_pix = {r_s, g_s, b_s, w_s};
            ORDER_BRG: packed_pix = {b_s, r_s, g_s, w_s};
            default:   packed_pix = {g_s, r_s, b_s, w_s};
        endcase
    end

    always_comb begin
        state_next = state;
        pix_ready  = 1'b0;
        pix_done   = 1'b0;
        frame_done = 1'b0;
        underrun   = 1'b0;
        busy       = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (frame_start && frame_len != '0) state_next = S_WAIT;
            end
            S_WAIT: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    state_next = S_SEND;
                end else if (gap_cnt == GAP_W'(UNDER_CYC - 1)) begin
                    underrun   = 1'b1;
                    state_next = S_LATCH;
                end
            end
            S_SEND: begin
                if (bit_end && bit_cnt == 5'd0) begin
                    pix_done   = 1'b1;
                    state_next = (led_cnt == len_q - IDX_W'(1)) ? S_LATCH : S_WAIT;
                end
            end
            S_LATCH: begin
                if (lat_cnt == LAT_W'(RST_CYC - 1)) begin
                    frame_done = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_LATCH;
            len_q   <= '0;
            bri_q   <= '0;
            led_cnt <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            lat_cnt <= '0;
            dout_q  <= 1'b0;
        end else begin
            state   <= state_next;
            dout_q  <= (state == S_SEND) && timer_dout;
            gap_cnt <= (state == S_WAIT) ? gap_cnt + GAP_W'(1) : '0;
            lat_cnt <= (state == S_LATCH) ? lat_cnt + LAT_W'(1) : '0;
            if (state == S_IDLE && state_next == S_WAIT) begin
                len_q   <= frame_len;
                bri_q   <= brightness;
                led_cnt <= '0;
            end
            if (state == S_WAIT && pix_valid) begin
                shreg   <= packed_pix;
                bit_cnt <= 5'(BPL - 1);
            end
            if (state == S_SEND && bit_end) begin
                shreg <= {shreg[30:0], 1'b0};
                if (bit_cnt == 5'd0) begin
                    led_cnt <= led_cnt + IDX_W'(1);
                end else begin
                    bit_cnt <= bit_cnt - 5'd1;
                end
            end
        end
    end

    assign dout = dout_q;

endmodule
